eth_rx_mac_filter: RTL and testbench
====================================

Name: eth_rx_mac_filter

Overview:
Receive-path destination-address filter placed directly downstream of the 1G MAC receive AXI-stream output, in the MAC receive clock domain. It holds the first 6 bytes of each frame and compares the destination MAC against the local address, broadcast and multicast. It then forwards the whole frame unchanged or silently discards it. Neither side has backpressure (no tready), matching the MAC receive stream.

Parameters:
DROP_COUNT_WIDTH, 16, width of saturating dropped-frame counter

Ports:
clk  input  1  receive clock (MAC rx_clk)
rst  input  1  synchronous active-high reset
s_axis_tdata  input  8  frame byte from MAC
s_axis_tvalid  input  1  byte valid (may be sparse, e.g. every other cycle in MII mode)
s_axis_tlast  input  1  last byte of frame
s_axis_tuser  input  1  bad-frame flag, valid with tlast
m_axis_tdata  output  8  filtered frame byte
m_axis_tvalid  output  1  output byte valid
m_axis_tlast  output  1  last byte of forwarded frame
m_axis_tuser  output  1  bad-frame flag copied from input tlast beat
local_mac  input  48  station address; local_mac[47:40] is first byte on wire
promiscuous  input  1  accept every frame
accept_broadcast  input  1  accept dest FF:FF:FF:FF:FF:FF
accept_multicast  input  1  accept dest with byte0 bit0 set (non-broadcast)
frame_accepted  output  1  one-cycle pulse at decision = pass
frame_dropped  output  1  one-cycle pulse when a frame is discarded
drain_overrun  output  1  one-cycle pulse when an input beat arrives during DRAIN
drop_count  output  DROP_COUNT_WIDTH  saturating count of dropped frames

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all m_axis_* = 0, all pulses = 0, drop_count = 0, hold buffer emptied, state IDLE.
- Hold buffer: 6 x 8-bit entries plus a write index of 0..6.
- States: IDLE, HDR, PASS, DROP, DRAIN.
- IDLE: on the first valid beat, store it at index 0 and go to HDR (or DROP runt path if tlast is also set).
- HDR: store each valid beat at the next index.
  - On the 6th stored byte, evaluate. match = promiscuous | (dest==local_mac) | (accept_broadcast & dest==all-ones) | (accept_multicast & dest[40] & dest!=all-ones).
  - Config inputs are sampled only in this decision cycle.
  - match=1: frame_accepted pulse next cycle. Go to PASS, or to DRAIN if that 6th byte carried tlast.
  - match=0: frame_dropped pulse, drop_count+1 (saturating at all-ones). Go to DROP, or to IDLE if tlast.
- Runt: tlast before 6 bytes stored → frame_dropped pulse, drop_count+1, back to IDLE, nothing output.
- PASS: each valid input beat n (0-based, n≥6) pushes into the buffer and pops byte n-6.
  - The popped byte is registered on m_axis with tvalid=1 and tlast=0 the following cycle. Latency is 1 cycle + 6 input beats.
  - On the input tlast beat, go to DRAIN and latch s_axis_tuser.
- DRAIN: output the remaining 6 buffered bytes on 6 consecutive cycles.
  - The 6th byte has tlast=1 and tuser = latched value; then go to IDLE.
  - Input beats arriving in DRAIN are discarded and raise drain_overrun. IFG plus preamble guarantee this cannot happen with a conforming MAC.
- DROP: consume beats without output until tlast, then go to IDLE.
- m_axis_tvalid is high only on cycles carrying a byte. m_axis_tlast/tuser are 0 when tvalid=0.
- Input tuser on a non-last beat is ignored.
- Frames with input tuser=1 are still filtered on address and forwarded with tuser=1.
- rst mid-frame: abandon state immediately; no partial tlast is emitted; the next frame is treated fresh.

Test Plan:
- local_mac=02:00:00:00:00:01, 64-byte frame to that address, valid every cycle → 64 output bytes identical, first output 7 cycles after first input, tlast on byte 63, one frame_accepted pulse.
- Same frame to 02:00:00:00:00:02, promiscuous=0 → no m_axis_tvalid, frame_dropped pulse, drop_count=1.
- Broadcast frame with accept_broadcast=0 then 1 → first dropped, second passed; multicast 01:00:5E:00:00:01 with accept_multicast=1 → passed.
- 4-byte runt with tlast → dropped, drop_count increments, no output; following valid frame passes intact.
- Sparse input (valid every other cycle, MII mode) 60-byte matching frame ending with tuser=1 → 60 bytes out, last 6 on consecutive cycles, final byte tlast=1 tuser=1.
- Assert rst during PASS at byte 20 → outputs 0 next cycle; next frame passes normally. Drive 2^16 bad frames with DROP_COUNT_WIDTH=16 → drop_count saturates at 0xFFFF.

Source files
------------

// File: rtl/eth_rx_mac_filter.sv
`default_nettype none
// ============================================================================
// Module   : eth_rx_mac_filter
// Summary  : Receive-path destination MAC filter. Holds the first six bytes of
//            each frame, decides pass/drop, then forwards or discards it.
// Revision : 1.0 - initial release
// ============================================================================
module eth_rx_mac_filter #(
    parameter int DROP_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    input  logic [47:0]                 local_mac,
    input  logic                        promiscuous,
    input  logic                        accept_broadcast,
    input  logic                        accept_multicast,
    output logic                        frame_accepted,
    output logic                        frame_dropped,
    output logic                        drain_overrun,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    localparam int          c_HDR_BYTES = 6;
    localparam logic [47:0] c_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_PASS  = 3'd2,
        S_DROP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                      r_state;
    logic [7:0]                  r_buf [c_HDR_BYTES];
    logic [2:0]                  r_wr_idx;
    logic [2:0]                  r_drain_cnt;
    logic                        r_tuser_hold;
    logic [7:0]                  r_tdata;
    logic                        r_tvalid;
    logic                        r_tlast;
    logic                        r_tuser;
    logic                        r_accepted;
    logic                        r_dropped;
    logic                        r_overrun;
    logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

    logic [47:0]                 w_dest;
    logic                        w_is_bcast;
    logic                        w_match;
    logic                        w_hdr_done;
    logic                        w_drain_done;
    logic [DROP_COUNT_WIDTH-1:0] w_drop_count_next;

    // Destination is only meaningful in the cycle the sixth byte arrives.
    assign w_dest       = {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], s_axis_tdata};
    assign w_is_bcast   = (w_dest == c_BCAST);
    assign w_match      = promiscuous
                        | (w_dest == local_mac)
                        | (accept_broadcast & w_is_bcast)
                        | (accept_multicast & w_dest[40] & ~w_is_bcast);
    assign w_hdr_done   = (r_wr_idx == 3'(c_HDR_BYTES - 1));
    assign w_drain_done = (r_drain_cnt == 3'(c_HDR_BYTES - 1));

    assign w_drop_count_next = (&r_drop_count) ? r_drop_count
                                               : r_drop_count + DROP_COUNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wr_idx     <= 3'd0;
            r_drain_cnt  <= 3'd0;
            r_tuser_hold <= 1'b0;
            r_tdata      <= 8'd0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tuser      <= 1'b0;
            r_accepted   <= 1'b0;
            r_dropped    <= 1'b0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
            for (int i = 0; i < c_HDR_BYTES; i++) begin
                r_buf[i] <= 8'd0;
            end
        end else begin
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_tuser    <= 1'b0;
            r_accepted <= 1'b0;
            r_dropped  <= 1'b0;
            r_overrun  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (s_axis_tvalid) begin
                        r_buf[0] <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            r_dropped    <= 1'b1;
                            r_drop_count <= w_drop_count_next;
                            r_wr_idx     <= 3'd0;
                        end else begin
                            r_wr_idx <= 3'd1;
                            r_state  <= S_HDR;
                        end
                    end
                end

                S_HDR: begin
                    if (s_axis_tvalid) begin
                        for (int i = 1; i < c_HDR_BYTES; i++) begin
                            if (r_wr_idx == 3'(i)) begin
                                r_buf[i] <= s_axis_tdata;
                            end
                        end
                        r_wr_idx <= r_wr_idx + 3'd1;
                        if (w_hdr_done) begin
                            r_tuser_hold <= s_axis_tuser;
                            r_drain_cnt  <= 3'd0;
                            if (w_match) begin
                                r_accepted <= 1'b1;
                                r_state    <= s_axis_tlast ? S_DRAIN : S_PASS;
                            end else begin
                                r_dropped    <= 1'b1;
                                r_drop_count <= w_drop_count_next;
                                r_state      <= s_axis_tlast ? S_IDLE : S_DROP;
                            end
                        end else if (s_axis_tlast) begin
                            r_dropped    <= 1'b1;
                            r_drop_count <= w_drop_count_next;
                            r_state      <= S_IDLE;
                        end
                    end
                end

                // Six-deep delay line: each new byte pushes out the one six beats older.
                S_PASS: begin
                    if (s_axis_tvalid) begin
                        r_tdata  <= r_buf[0];
                        r_tvalid <= 1'b1;
                        for (int i = 0; i < c_HDR_BYTES - 1; i++) begin
                            r_buf[i] <= r_buf[i+1];
                        end
                        r_buf[c_HDR_BYTES-1] <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            r_tuser_hold <= s_axis_tuser;
                            r_drain_cnt  <= 3'd0;
                            r_state      <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    r_tdata     <= r_buf[0];
                    r_tvalid    <= 1'b1;
                    r_overrun   <= s_axis_tvalid;
                    r_drain_cnt <= r_drain_cnt + 3'd1;
                    for (int i = 0; i < c_HDR_BYTES - 1; i++) begin
                        r_buf[i] <= r_buf[i+1];
                    end
                    if (w_drain_done) begin
                        r_tlast  <= 1'b1;
                        r_tuser  <= r_tuser_hold;
                        r_wr_idx <= 3'd0;
                        r_state  <= S_IDLE;
                    end
                end

                S_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_wr_idx <= 3'd0;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata   = r_tdata;
    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tlast   = r_tlast;
    assign m_axis_tuser   = r_tuser;
    assign frame_accepted = r_accepted;
    assign frame_dropped  = r_dropped;
    assign drain_overrun  = r_overrun;
    assign drop_count     = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_mac_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_rx_mac_filter
// Summary  : Directed plus random frames against an address-rule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_rx_mac_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [47:0] local_mac = 48'h02_00_00_00_00_01;
    logic        promiscuous = 1'b0;
    logic        accept_broadcast = 1'b0;
    logic        accept_multicast = 1'b0;
    logic        frame_accepted;
    logic        frame_dropped;
    logic        drain_overrun;
    logic [15:0] drop_count;

    logic [7:0]  s4_tdata;
    logic        s4_tvalid, s4_tlast, s4_tuser, s4_acc, s4_drp, s4_ovr;
    logic [3:0]  s4_drop_count;

    eth_rx_mac_filter #(.DROP_COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .local_mac(local_mac), .promiscuous(promiscuous),
        .accept_broadcast(accept_broadcast), .accept_multicast(accept_multicast),
        .frame_accepted(frame_accepted), .frame_dropped(frame_dropped),
        .drain_overrun(drain_overrun), .drop_count(drop_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    eth_rx_mac_filter #(.DROP_COUNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(s4_tdata), .m_axis_tvalid(s4_tvalid),
        .m_axis_tlast(s4_tlast), .m_axis_tuser(s4_tuser),
        .local_mac(local_mac), .promiscuous(promiscuous),
        .accept_broadcast(accept_broadcast), .accept_multicast(accept_multicast),
        .frame_accepted(s4_acc), .frame_dropped(s4_drp),
        .drain_overrun(s4_ovr), .drop_count(s4_drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: beats as {data, last, user}, plus pulse tallies.
    logic [9:0] out_q[$];
    int         out_cyc[$];
    int         n_acc = 0, n_drp = 0, n_ovr = 0;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            out_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            out_cyc.push_back(cyc);
        end else begin
            chk("quiet_sideband", {62'd0, m_axis_tlast, m_axis_tuser}, 64'd0);
        end
        if (frame_accepted) n_acc++;
        if (frame_dropped)  n_drp++;
        if (drain_overrun)  n_ovr++;
    end

    // Reference model state.
    logic [7:0] fq[$];
    logic [9:0] exp_q[$];
    int         exp_acc = 0, exp_drp = 0, exp_ovr = 0;
    int         model_drops = 0;
    int         in_cyc0 = 0;

    function automatic bit ref_match(input logic [47:0] d);
        bit bc;
        bc = (d == 48'hFFFF_FFFF_FFFF);
        return promiscuous || (d == local_mac) || (accept_broadcast && bc)
               || (accept_multicast && d[40] && !bc);
    endfunction

    task automatic build_frame(input logic [47:0] dest, input int len);
        fq.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) fq.push_back(dest[47-8*i -: 8]);
            else       fq.push_back(8'($urandom));
        end
    endtask

    task automatic drive_idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tdata  = 8'($urandom);
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random gaps.
    task automatic send_frame(input int gap_mode, input bit user, input bit extra);
        int          n;
        bit          ok;
        logic [47:0] d;
        n = fq.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int g;
                g = (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode;
                repeat (g) begin
                    @(negedge clk);
                    drive_idle();
                end
            end
            @(negedge clk);
            if (i == 0) in_cyc0 = cyc;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fq[i];
            s_axis_tlast  = (i == n - 1);
            s_axis_tuser  = (i == n - 1) ? user : 1'($urandom);
        end
        if (extra) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 8'($urandom);
            s_axis_tlast  = 1'b1;
            s_axis_tuser  = 1'b0;
            exp_ovr++;
        end
        @(negedge clk);
        drive_idle();

        if (n < 6) begin
            ok = 1'b0;
        end else begin
            d  = {fq[0], fq[1], fq[2], fq[3], fq[4], fq[5]};
            ok = ref_match(d);
        end
        if (ok) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({fq[i], 1'(i == n - 1), 1'((i == n - 1) && user)});
            exp_acc++;
        end else begin
            exp_drp++;
            model_drops++;
        end
    endtask

    task automatic clear_obs();
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
        n_acc = 0; n_drp = 0; n_ovr = 0;
        exp_acc = 0; exp_drp = 0; exp_ovr = 0;
    endtask

    task automatic check_frame(input string tag);
        repeat (14) @(negedge clk);
        chk({tag, ".len"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk({tag, ".beat"}, 64'(out_q[i]), 64'(exp_q[i]));
        chk({tag, ".accepted"}, 64'(n_acc), 64'(exp_acc));
        chk({tag, ".dropped"},  64'(n_drp), 64'(exp_drp));
        chk({tag, ".overrun"},  64'(n_ovr), 64'(exp_ovr));
        chk({tag, ".drop_count"}, 64'(drop_count),
            64'((model_drops > 65535) ? 65535 : model_drops));
        chk({tag, ".drop_count_sat"}, 64'(s4_drop_count),
            64'((model_drops > 15) ? 15 : model_drops));
        clear_obs();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("reset.tdata",  64'(m_axis_tdata),  64'd0);
        chk("reset.pulses", {61'd0, frame_accepted, frame_dropped, drain_overrun}, 64'd0);
        chk("reset.drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        clear_obs();

        // Matching 64-byte frame, valid every cycle.
        build_frame(48'h02_00_00_00_00_01, 64);
        send_frame(0, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        chk("match64.latency", 64'((out_cyc.size() > 0) ? out_cyc[0] - in_cyc0 : -1), 64'd7);
        check_frame("match64");

        build_frame(48'h02_00_00_00_00_02, 64);
        send_frame(0, 1'b0, 1'b0);
        check_frame("other_unicast");

        build_frame(48'hFF_FF_FF_FF_FF_FF, 30);
        send_frame(0, 1'b0, 1'b0);
        check_frame("bcast_off");
        accept_broadcast = 1'b1;
        build_frame(48'hFF_FF_FF_FF_FF_FF, 30);
        send_frame(0, 1'b0, 1'b0);
        check_frame("bcast_on");

        build_frame(48'h01_00_5E_00_00_01, 40);
        send_frame(0, 1'b0, 1'b0);
        check_frame("mcast_off");
        accept_multicast = 1'b1;
        build_frame(48'h01_00_5E_00_00_01, 40);
        send_frame(0, 1'b0, 1'b0);
        check_frame("mcast_on");

        build_frame(local_mac, 4);
        send_frame(0, 1'b0, 1'b0);
        check_frame("runt4");
        build_frame(local_mac, 20);
        send_frame(0, 1'b0, 1'b0);
        check_frame("after_runt");

        // MII-style sparse input, bad-frame flag on the last beat.
        build_frame(local_mac, 60);
        send_frame(1, 1'b1, 1'b0);
        repeat (14) @(negedge clk);
        chk("sparse.tail_consecutive",
            64'((out_cyc.size() == 60) ? out_cyc[59] - out_cyc[54] : -1), 64'd5);
        check_frame("sparse60");

        // Six-byte frame straight into DRAIN, then a stray beat during DRAIN.
        build_frame(local_mac, 6);
        send_frame(0, 1'b1, 1'b1);
        check_frame("overrun");

        for (int k = 0; k < 12; k++) begin
            logic [47:0] d;
            case ($urandom_range(0, 3))
                0:       d = local_mac;
                1:       d = {16'($urandom) & 16'hFEFF, 32'($urandom)};
                2:       d = 48'hFF_FF_FF_FF_FF_FF;
                default: d = {16'($urandom) | 16'h0100, 32'($urandom)};
            endcase
            promiscuous      = 1'($urandom);
            accept_broadcast = 1'($urandom);
            accept_multicast = 1'($urandom);
            build_frame(d, int'($urandom_range(1, 40)));
            send_frame(int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
            check_frame("random");
        end
        promiscuous = 1'b0;

        for (int k = 0; k < 20; k++) begin
            build_frame(local_mac, 1);
            send_frame(0, 1'b0, 1'b0);
        end
        check_frame("runt_burst");
        chk("saturate.narrow", 64'(s4_drop_count), 64'hF);

        // Reset while passing byte 20.
        build_frame(local_mac, 64);
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = fq[i];
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        chk("midrst.tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst.tdata",  64'(m_axis_tdata),  64'd0);
        chk("midrst.drop_count", 64'(drop_count), 64'd0);
        rst = 1'b0;
        model_drops = 0;
        chk("midrst.partial_len", 64'(out_q.size()), 64'd15);
        for (int i = 0; i < out_q.size(); i++)
            chk("midrst.partial_beat", 64'(out_q[i]), 64'({fq[i], 2'b00}));
        clear_obs();

        build_frame(local_mac, 48);
        send_frame(2, 1'b0, 1'b0);
        check_frame("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
